// File: rtl/nrdiv_seq_ctrl.sv
// Sequential unsigned non-restoring divider: N add/subtract iterations plus one remainder fix-up.
// Optional NRDIV_DBZ_FAST_EN: divide-by-zero short-circuits straight to DONE with o_dbz set.
module nrdiv_seq_ctrl #(
   parameter int N = 8,
   localparam int CNT_W = $clog2(N) + 1
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [N-1:0] i_dividend,
   input  logic [N-1:0] i_divisor,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [N-1:0] o_quotient,
   output logic [N-1:0] o_remainder,
   output logic         o_dbz
);

   typedef enum logic [1:0] {IDLE, ITER, CORR, DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   state_t           state_reg;
   logic [N:0]       p_reg;
   logic [N-1:0]     q_reg;
   logic [N-1:0]     d_reg;
   logic [CNT_W-1:0] cnt_reg;

   logic [N:0] d_ext;
   logic [N:0] p_shift;
   logic [N:0] p_step;
   logic [N:0] p_fix;

   // Sign of the old partial remainder picks subtract or add for this step.
   assign d_ext   = {1'b0, d_reg};
   assign p_shift = {p_reg[N-1:0], q_reg[N-1]};
   assign p_step  = p_reg[N] ? (p_shift + d_ext) : (p_shift - d_ext);
   assign p_fix   = p_reg[N] ? (p_reg + d_ext) : p_reg;

`ifdef NRDIV_DBZ_FAST_EN
   logic dbz_reg;
   assign o_dbz = dbz_reg;
`else
   assign o_dbz = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg   <= IDLE;
         p_reg       <= '0;
         q_reg       <= '0;
         d_reg       <= '0;
         cnt_reg     <= '0;
         o_ready     <= 1'b1;
         o_valid     <= 1'b0;
         o_quotient  <= '0;
         o_remainder <= '0;
`ifdef NRDIV_DBZ_FAST_EN
         dbz_reg     <= 1'b0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (i_valid) begin
                  d_reg   <= i_divisor;
                  q_reg   <= i_dividend;
                  p_reg   <= '0;
                  cnt_reg <= '0;
                  o_ready <= 1'b0;
`ifdef NRDIV_DBZ_FAST_EN
                  if (i_divisor == '0) begin
                     state_reg   <= DONE;
                     o_valid     <= 1'b1;
                     o_quotient  <= '1;
                     o_remainder <= i_dividend;
                     dbz_reg     <= 1'b1;
                  end else begin
                     state_reg <= ITER;
                     dbz_reg   <= 1'b0;
                  end
`else
                  state_reg <= ITER;
`endif
               end
            end
            ITER: begin
               p_reg   <= p_step;
               q_reg   <= {q_reg[N-2:0], ~p_step[N]};
               cnt_reg <= cnt_reg + 1'b1;
               if (cnt_reg == CNT_LAST) begin
                  state_reg <= CORR;
               end
            end
            CORR: begin
               p_reg       <= p_fix;
               o_quotient  <= q_reg;
               o_remainder <= p_fix[N-1:0];
               o_valid     <= 1'b1;
               state_reg   <= DONE;
            end
            DONE: begin
               if (i_ready) begin
                  o_valid   <= 1'b0;
                  o_ready   <= 1'b1;
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
